// File: rtl/mel_vector_serializer.sv
// mel_vector_serializer
//   Captures a parallel frame of NUM_BANKS mel-bank dB energies into a
//   two-entry ping-pong store. It then streams each frame out one word per
//   handshake, in capture order and in bank order 0..NUM_BANKS-1.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   in[]         parallel frame, element 0 = lowest-frequency bank
//   s_valid      in[] holds a complete frame
//   s_ready      a frame can be captured this cycle (registered)
//   out          current serialized energy word
//   m_index      bank index of out
//   m_last       out is the final bank of its frame
//   m_valid      out/m_index/m_last are valid
//   m_ready      downstream accepts the current word
//   frame_count  frames fully emitted since reset (wraps)
module mel_vector_serializer #(
    parameter int unsigned NUM_BANKS = 40,
    parameter int unsigned DATA_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in [NUM_BANKS],
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] out,
    output logic [5:0]        m_index,
    output logic              m_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [15:0]       frame_count
);

    localparam int unsigned IDX_W = 6;
    localparam int unsigned CNT_W = 16;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BANKS - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t state;
    state_t state_d;

    // Ping-pong frame store; contents carry no reset, only occupancy does.
    logic [DATA_W-1:0] mem [2][NUM_BANKS];

    logic [1:0]        full;
    logic [1:0]        full_d;
    logic              wr_ptr;
    logic              rd_ptr;
    logic              nx_ptr;
    logic              capture;
    logic              last_hs;
    logic              s_ready_d;
    logic [IDX_W-1:0]  idx_inc;

    logic [DATA_W-1:0] out_d;
    logic [IDX_W-1:0]  idx_d;
    logic              last_d;
    logic              valid_d;

    assign capture = s_valid & s_ready;
    assign last_hs = m_valid & m_ready & m_last;
    assign nx_ptr  = ~rd_ptr;
    assign idx_inc = m_index + IDX_W'(1);

    // Occupancy next state: release and capture on one edge both apply.
    // With one buffer full, wr_ptr always names the other one, so the two
    // updates never touch the same bit.
    always_comb begin
        full_d = full;
        if (last_hs) begin
            full_d[rd_ptr] = 1'b0;
        end
        if (capture) begin
            full_d[wr_ptr] = 1'b1;
        end
        s_ready_d = (full_d != 2'b11);
    end

    // Occupancy, FIFO pointers and s_ready. s_ready is low during reset
    // and first rises on the first edge after release, so it also acts as
    // the ready-enable flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full    <= 2'b00;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            s_ready <= 1'b0;
        end else begin
            full    <= full_d;
            s_ready <= s_ready_d;
            if (capture) begin
                wr_ptr <= ~wr_ptr;
            end
            if (last_hs) begin
                rd_ptr <= ~rd_ptr;
            end
        end
    end

    // Frame capture into the free buffer.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int unsigned k = 0; k < NUM_BANKS; k++) begin
                mem[wr_ptr][k] <= in[k];
            end
        end
    end

    // Output FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Output FSM next state and next output word. A frame arriving while
    // nothing else is queued bypasses the store straight into the output
    // register. This gives one-cycle latency from idle and no bubble
    // between frames.
    always_comb begin
        state_d = state;
        out_d   = out;
        idx_d   = m_index;
        last_d  = m_last;
        valid_d = m_valid;
        unique case (state)
            IDLE: begin
                if (capture) begin
                    state_d = STREAM;
                    out_d   = in[0];
                    idx_d   = '0;
                    last_d  = (LAST_IDX == '0);
                    valid_d = 1'b1;
                end
            end
            STREAM: begin
                if (m_ready) begin
                    if (m_last) begin
                        if (full[nx_ptr]) begin
                            out_d  = mem[nx_ptr][0];
                            idx_d  = '0;
                            last_d = (LAST_IDX == '0);
                        end else if (capture) begin
                            out_d  = in[0];
                            idx_d  = '0;
                            last_d = (LAST_IDX == '0);
                        end else begin
                            state_d = IDLE;
                            out_d   = '0;
                            idx_d   = '0;
                            last_d  = 1'b0;
                            valid_d = 1'b0;
                        end
                    end else begin
                        out_d  = mem[rd_ptr][idx_inc];
                        idx_d  = idx_inc;
                        last_d = (idx_inc == LAST_IDX);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Registered output word, index, flags and completed-frame counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out         <= '0;
            m_index     <= '0;
            m_last      <= 1'b0;
            m_valid     <= 1'b0;
            frame_count <= '0;
        end else begin
            out     <= out_d;
            m_index <= idx_d;
            m_last  <= last_d;
            m_valid <= valid_d;
            if (last_hs) begin
                frame_count <= frame_count + CNT_W'(1);
            end
        end
    end

    // Structural invariants of the output stream and the store.
    a_last_consistent: assert property (@(posedge clk) disable iff (!reset)
        m_last == (m_valid && (m_index == LAST_IDX)));
    a_idle_zero: assert property (@(posedge clk) disable iff (!reset)
        !m_valid |-> ((out == '0) && (m_index == '0)));
    a_no_overwrite: assert property (@(posedge clk) disable iff (!reset)
        capture |-> !full[wr_ptr]);

endmodule

// File: tb/tb_mel_vector_serializer.sv
// Directed self-checking bench for mel_vector_serializer.
module tb_mel_vector_serializer;

    localparam int NB = 40;

    logic        clk;
    logic        reset;
    logic [15:0] din [NB];
    logic        s_valid;
    logic        s_ready;
    logic [15:0] dout;
    logic [5:0]  m_index;
    logic        m_last;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] frame_count;

    // Single-bank instance used for the frame_count wrap test.
    logic [15:0] din1 [1];
    logic        s_valid1;
    logic        s_ready1;
    logic [15:0] dout1;
    logic [5:0]  m_index1;
    logic        m_last1;
    logic        m_valid1;
    logic        m_ready1;
    logic [15:0] frame_count1;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          exp_fc   = 0;
    logic [15:0] exp_q [$];

    mel_vector_serializer #(.NUM_BANKS(NB), .DATA_W(16)) dut (
        .clk(clk), .reset(reset), .in(din), .s_valid(s_valid), .s_ready(s_ready),
        .out(dout), .m_index(m_index), .m_last(m_last), .m_valid(m_valid),
        .m_ready(m_ready), .frame_count(frame_count)
    );

    mel_vector_serializer #(.NUM_BANKS(1), .DATA_W(16)) dut1 (
        .clk(clk), .reset(reset), .in(din1), .s_valid(s_valid1), .s_ready(s_ready1),
        .out(dout1), .m_index(m_index1), .m_last(m_last1), .m_valid(m_valid1),
        .m_ready(m_ready1), .frame_count(frame_count1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load_frame(input logic [15:0] base);
        for (int k = 0; k < NB; k++) din[k] = base + 16'(k);
    endtask

    // Offer one frame; returns at the negedge after it is captured.
    task automatic send_frame(input logic [15:0] base);
        int b = 0;
        load_frame(base);
        s_valid = 1'b1;
        while (!s_ready && b < 2000) begin
            tick();
            b++;
        end
        if (!s_ready) begin
            check_eq("send_timeout", 32'(b), 32'(0));
        end else begin
            @(posedge clk);
            exp_q.push_back(base);
            @(negedge clk);
        end
        s_valid = 1'b0;
    endtask

    // Accept nwords words with m_ready following the 4-cycle pattern pat.
    // Every cycle with m_valid checks the word against the scoreboard.
    task automatic consume(input int nwords, input logic [3:0] pat, input bit contig);
        int k = 0;
        int got = 0;
        int cyc = 0;
        bit started = 1'b0;
        logic [15:0] e;
        while (got < nwords && cyc < 4000) begin
            m_ready = pat[cyc % 4];
            if (exp_q.size() == 0) begin
                check_eq("unexpected_valid", 32'(m_valid), 32'(0));
            end else if (m_valid) begin
                started = 1'b1;
                e = exp_q[0] + 16'(k);
                check_eq("word", 32'(dout), 32'(e));
                check_eq("index", 32'(m_index), 32'(k));
                check_eq("last", 32'(m_last), 32'(k == NB - 1));
                if (m_ready) begin
                    k++;
                    got++;
                    if (k == NB) begin
                        k = 0;
                        void'(exp_q.pop_front());
                        exp_fc++;
                    end
                end
            end else if (contig && started) begin
                check_eq("bubble", 32'(m_valid), 32'(1));
            end
            tick();
            cyc++;
        end
        if (got < nwords) check_eq("consume_timeout", 32'(got), 32'(nwords));
        m_ready = 1'b0;
    endtask

    initial begin
        int b;
        reset    = 1'b0;
        s_valid  = 1'b0;
        m_ready  = 1'b0;
        s_valid1 = 1'b0;
        m_ready1 = 1'b0;
        din1[0]  = 16'h0000;
        load_frame(16'h0000);

        // Reset values
        repeat (2) @(negedge clk);
        check_eq("rst_s_ready", 32'(s_ready), 32'(0));
        check_eq("rst_m_valid", 32'(m_valid), 32'(0));
        check_eq("rst_m_last", 32'(m_last), 32'(0));
        check_eq("rst_out", 32'(dout), 32'(0));
        check_eq("rst_index", 32'(m_index), 32'(0));
        check_eq("rst_frame_count", 32'(frame_count), 32'(0));
        reset = 1'b1;
        check_eq("ready_before_edge", 32'(s_ready), 32'(0));
        tick();
        check_eq("ready_after_edge", 32'(s_ready), 32'(1));

        // Single frame, one-cycle latency, continuous m_ready
        send_frame(16'h0100);
        check_eq("latency_valid", 32'(m_valid), 32'(1));
        check_eq("latency_word", 32'(dout), 32'h0100);
        check_eq("latency_index", 32'(m_index), 32'(0));
        check_eq("single_s_ready", 32'(s_ready), 32'(1));
        consume(NB, 4'b1111, 1'b1);
        check_eq("single_idle_valid", 32'(m_valid), 32'(0));
        check_eq("single_idle_out", 32'(dout), 32'(0));
        check_eq("single_idle_last", 32'(m_last), 32'(0));
        check_eq("single_frame_count", 32'(frame_count), 32'(1));

        // Backpressure pattern 1,0,0,1 over two frames
        fork
            begin
                send_frame(16'h2000);
                send_frame(16'h2100);
            end
            consume(2 * NB, 4'b1001, 1'b0);
        join
        check_eq("bp_frame_count", 32'(frame_count), 32'(exp_fc));
        check_eq("bp_idle", 32'(m_valid), 32'(0));

        // Fill both buffers with m_ready low; third frame waits
        m_ready = 1'b0;
        load_frame(16'h0A00);
        s_valid = 1'b1;
        tick();
        check_eq("fill_ready_one", 32'(s_ready), 32'(1));
        check_eq("fill_valid", 32'(m_valid), 32'(1));
        load_frame(16'h0B00);
        tick();
        check_eq("fill_ready_two", 32'(s_ready), 32'(0));
        load_frame(16'h0C00);
        repeat (3) begin
            tick();
            check_eq("fill_stall_ready", 32'(s_ready), 32'(0));
            check_eq("fill_stall_word", 32'(dout), 32'h0A00);
            check_eq("fill_stall_index", 32'(m_index), 32'(0));
        end
        m_ready = 1'b1;
        for (int k = 0; k < NB; k++) begin
            check_eq("fill_drain_word", 32'(dout), 32'(16'h0A00 + 16'(k)));
            check_eq("fill_held", 32'(s_ready), 32'(0));
            tick();
        end
        exp_fc++;
        check_eq("fill_freed", 32'(s_ready), 32'(1));
        check_eq("fill_next_valid", 32'(m_valid), 32'(1));
        check_eq("fill_next_word", 32'(dout), 32'h0B00);
        check_eq("fill_next_index", 32'(m_index), 32'(0));
        m_ready = 1'b0;
        tick();
        s_valid = 1'b0;
        check_eq("fill_third_captured", 32'(s_ready), 32'(0));
        exp_q.push_back(16'h0B00);
        exp_q.push_back(16'h0C00);
        consume(2 * NB, 4'b1111, 1'b1);
        check_eq("fill_frame_count", 32'(frame_count), 32'(exp_fc));

        // Continuous streaming of four frames
        fork
            begin
                for (int f = 0; f < 4; f++) send_frame(16'h3000 + 16'(f * 256));
            end
            consume(4 * NB, 4'b1111, 1'b1);
        join
        check_eq("stream_frame_count", 32'(frame_count), 32'(exp_fc));

        // Reset mid-stream at index 17
        send_frame(16'h4000);
        m_ready = 1'b1;
        b = 0;
        while (!(m_valid && m_index == 6'd17) && b < 200) begin
            tick();
            b++;
        end
        check_eq("reach_index_17", 32'(m_index), 32'(17));
        reset = 1'b0;
        #1;
        check_eq("midrst_valid", 32'(m_valid), 32'(0));
        check_eq("midrst_frame_count", 32'(frame_count), 32'(0));
        check_eq("midrst_s_ready", 32'(s_ready), 32'(0));
        check_eq("midrst_index", 32'(m_index), 32'(0));
        exp_q.delete();
        exp_fc = 0;
        m_ready = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        tick();
        check_eq("postrst_s_ready", 32'(s_ready), 32'(1));
        m_ready = 1'b1;
        repeat (3) begin
            tick();
            check_eq("postrst_no_partial", 32'(m_valid), 32'(0));
        end
        m_ready = 1'b0;
        send_frame(16'h5000);
        check_eq("postrst_index0", 32'(m_index), 32'(0));
        check_eq("postrst_word0", 32'(dout), 32'h5000);
        consume(NB, 4'b1111, 1'b1);
        check_eq("postrst_frame_count", 32'(frame_count), 32'(1));

        // frame_count wrap on a one-bank instance: one frame per cycle
        din1[0]  = 16'hBEEF;
        s_valid1 = 1'b1;
        m_ready1 = 1'b1;
        b = 0;
        while (frame_count1 != 16'hFFFF && b < 70000) begin
            tick();
            b++;
        end
        check_eq("wrap_reach_65535", 32'(frame_count1), 32'hFFFF);
        check_eq("wrap_valid", 32'(m_valid1), 32'(1));
        check_eq("wrap_last", 32'(m_last1), 32'(1));
        check_eq("wrap_word", 32'(dout1), 32'hBEEF);
        check_eq("wrap_index", 32'(m_index1), 32'(0));
        tick();
        check_eq("wrap_to_zero", 32'(frame_count1), 32'(0));
        s_valid1 = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mel_vector_serializer.md
MEL_VECTOR_SERIALIZER -- requirements
Module: mel_vector_serializer

Interface
REQ-001 Parameter NUM_BANKS, default 40, number of mel-bank energies per frame vector.
REQ-002 Parameter DATA_W, default 16, width of one dB energy word.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted), single clock domain.
REQ-005 in  input  DATA_W x NUM_BANKS (unpacked array in[NUM_BANKS])  parallel frame of mel energies; element 0 is the lowest-frequency bank.
REQ-006 s_valid  input  1  in[] holds a complete frame.
REQ-007 s_ready  output  1  block can capture a frame this cycle.
REQ-008 out  output  DATA_W  current serialized energy word.
REQ-009 m_index  output  6  bank index of out (0..NUM_BANKS-1).
REQ-010 m_last  output  1  out is bank NUM_BANKS-1 of its frame.
REQ-011 m_valid  output  1  out/m_index/m_last are valid.
REQ-012 m_ready  input  1  downstream accepts the current word.
REQ-013 frame_count  output  16  number of frames fully emitted since reset.

Function
REQ-014 Capture: on a rising edge with s_valid=1 and s_ready=1, all NUM_BANKS words of in[] SHALL be copied into one free buffer of a two-entry ping-pong store.
REQ-015 s_ready SHALL be 1 only when the ready-enable register is 1 and fewer than 2 buffers are full; it SHALL NOT depend combinationally on m_ready or s_valid.
REQ-016 A buffer freed on an edge (last-word handshake) SHALL count as free starting the next cycle; no same-edge reuse.
REQ-017 Frames SHALL be emitted in capture order (FIFO across the two buffers); words within a frame in index order 0..NUM_BANKS-1.
REQ-018 Output state machine: IDLE (m_valid=0) and STREAM (m_valid=1); IDLE->STREAM on the edge after any buffer becomes full; STREAM->IDLE on last-word handshake when no other buffer is full; STREAM->STREAM (index 0 of next frame) on last-word handshake when the other buffer is full.
REQ-019 Latency: a frame captured at edge N into an empty block SHALL present index 0 with m_valid=1 after edge N+1... precisely, out/m_valid are registered and valid in the cycle following edge N.
REQ-020 Back-to-back frames SHALL stream with zero bubble cycles between m_last of one frame and index 0 of the next.
REQ-021 Word advance: index increments by 1 on each edge with m_valid=1 and m_ready=1; otherwise out, m_index, m_last SHALL hold unchanged.
REQ-022 m_valid SHALL never deassert without a completing handshake.
REQ-023 m_last SHALL equal (m_index == NUM_BANKS-1) whenever m_valid=1; 0 otherwise.
REQ-024 frame_count SHALL increment by 1 on each handshake with m_last=1, wrapping 65535 -> 0.
REQ-025 Simultaneous capture and last-word handshake on the same edge SHALL both take effect; buffer-full count net unchanged when one is captured and one released.
REQ-026 No frame is ever dropped or overwritten; upstream backpressure is the only flow-control mechanism.
REQ-027 out/m_index SHALL be 0 whenever m_valid=0.

Reset
REQ-028 While reset=0: s_ready=0, m_valid=0, m_last=0, out=0, m_index=0, frame_count=0, both buffers marked empty, state IDLE, ready-enable=0.
REQ-029 Ready-enable SHALL set to 1 on the first rising edge with reset=1, so s_ready rises one cycle after deassertion.
REQ-030 Reset asserted mid-frame SHALL discard all buffered data immediately (asynchronously); no partial frame is emitted afterwards.
REQ-031 Buffer data contents need not be reset; only valid/occupancy state.

Verification
REQ-032 Single frame, m_ready=1: in[k]=16'h0100+k captured at edge N -> 40 consecutive words 0x0100..0x0127, m_index 0..39, m_last only on 0x0127, frame_count 0->1.
REQ-033 Backpressure: m_ready toggled 1,0,0,1 repeatedly -> out/m_index held during stalls, no word skipped or repeated, exactly 40 handshakes per frame.
REQ-034 Fill: three frames offered back-to-back with m_ready=0 -> first two captured, s_ready=0 after second capture, third held until a last-word handshake frees a buffer one cycle earlier.
REQ-035 Continuous streaming: 4 frames with s_valid=1, m_ready=1 -> 160 words with m_valid continuously 1 after first, frame order preserved, frame_count=4.
REQ-036 Reset mid-stream at m_index=17 -> m_valid=0, frame_count=0 immediately; after release s_ready=1 one cycle later and next captured frame starts at index 0.
REQ-037 frame_count preloaded by streaming 65536 frames -> wraps to 0 on the 65536th m_last handshake.
